ultrasound_array_scanner: RTL and testbench
===========================================

Name: ultrasound_array_scanner

Overview:
Parametrised successor to the single-shot HC-SR04 ranging controller. Sweeps up to NUM_SENSORS ultrasound units in index order, skips masked-off channels, and reports a per-channel distance with saturation. Tracks the nearest channel over each sweep. Runs in single-sweep or continuous mode, and handles a missing echo rise, a stuck-high echo, and a mandatory inter-ping settle time. Sits between the top-level rover-location logic and the sensor pins.

Parameters:
NUM_SENSORS, 6, number of sensors, 1..16
TRIGGER_CYCLES, 275, trigger pulse length (~10 us at 27 MHz)
RISE_TIMEOUT_CYCLES, 27000, max wait for echo rise (1 ms)
ECHO_TIMEOUT_CYCLES, 1048576, max echo-high length (~38 ms)
POWER_CYCLE_CYCLES, 27000000, power-off time after echo timeout (1 s)
SETTLE_CYCLES, 1620000, quiet gap after each ping (60 ms)
DIST_SHIFT, 12, echo count >> DIST_SHIFT gives inches
DIST_OFFSET, 5, added after the shift
DIST_WIDTH, 8, width of distance outputs

Ports:
clock  in  1  system clock (27 MHz)
reset  in  1  synchronous, active-high reset
enable  in  1  level; starts a sweep when sampled high in IDLE
continuous  in  1  1 = start the next sweep automatically after SETTLE; sampled at end of each sweep
channel_mask  in  NUM_SENSORS  1 = channel included; latched at sweep start
ultrasound_response  in  NUM_SENSORS  raw echo inputs (asynchronous)
ultrasound_trigger  out  NUM_SENSORS  trigger outputs
ultrasound_power  out  NUM_SENSORS  per-sensor power enable, 1 = on
distance  out  DIST_WIDTH  last measured distance
distance_channel  out  4  channel index of distance
distance_valid  out  1  one-cycle strobe when distance is updated
timeout_flags  out  NUM_SENSORS  sticky per channel; set on rise or echo timeout, cleared when that channel next measures OK
min_distance  out  DIST_WIDTH  nearest distance of the last completed sweep
min_channel  out  4  channel index of min_distance
sweep_done  out  1  one-cycle strobe when a sweep completes
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - trigger = 0; power = all ones.
  - distance, distance_channel, distance_valid, sweep_done, timeout_flags, min_channel = 0.
  - min_distance = all ones.
  - State = IDLE.
  - Reset is honoured in any state, mid-ping or mid-power-cycle: triggers drop and power is restored on the next edge.
- ultrasound_response goes through a 2-flop synchronizer. All echo timing uses the synchronized signal, so echo edges are seen 2 cycles late. Counts are not compensated.
- States:
  - IDLE: on enable, latch channel_mask into mask_q, reset sweep min (value all ones, valid 0), go to SELECT with ch = 0.
  - SELECT: find the lowest ch' >= ch with mask_q[ch'] = 1.
    - If found: ch = ch', drive trigger[ch] = 1, go to TRIGGER.
    - If none: go to END.
    - Scans one index per cycle.
  - TRIGGER: hold for exactly TRIGGER_CYCLES cycles, then trigger[ch] = 0 and go to WAIT_RISE.
  - WAIT_RISE:
    - On echo high: count = 1, go to MEASURE.
    - If echo is still low after RISE_TIMEOUT_CYCLES cycles: result = all ones, set timeout_flags[ch], go to REPORT. No power cycle.
  - MEASURE: count increments each cycle while echo is high.
    - On echo low: raw = count >> DIST_SHIFT; result = raw + DIST_OFFSET, saturated to 2^DIST_WIDTH - 1. Clear timeout_flags[ch]. Go to REPORT.
    - If count reaches ECHO_TIMEOUT_CYCLES: result = all ones, set timeout_flags[ch], power[ch] = 0, go to POWER_CYCLE.
  - POWER_CYCLE: hold power[ch] = 0 for POWER_CYCLE_CYCLES cycles, then power[ch] = 1 and go to REPORT.
  - REPORT (one cycle):
    - distance = result, distance_channel = ch, distance_valid = 1.
    - If result < sweep min (strict), update the sweep min. Ties keep the lower index.
    - Go to SETTLE.
  - SETTLE: wait SETTLE_CYCLES cycles, then ch = ch + 1 and go to SELECT. If ch was NUM_SENSORS - 1, go to END instead.
  - END (one cycle):
    - min_distance and min_channel take the sweep min. If no channel reported, they become all ones / 0.
    - sweep_done = 1.
    - If continuous = 1: relatch channel_mask and go to SELECT with ch = 0.
    - Otherwise go to IDLE.
- Empty mask: SELECT falls straight to END, so sweep_done pulses with min_distance = all ones.
- Strobes: at most one of distance_valid and sweep_done is high per cycle. enable is ignored while busy.
- Only the active channel ever drives trigger high. No two triggers are ever high together.

Test Plan:
- Sim overrides TRIGGER=4, RISE_TO=50, ECHO_TO=200, POWER=30, SETTLE=10, DIST_SHIFT=2, OFFSET=5, N=4.
  - Mask 4'b1111, echo widths 40/20/60/20 cycles (width measured on the synchronized echo) -> distances 15/10/20/10; min_distance 10, min_channel 1; sweep_done once.
  - Mask 4'b0101 -> only ch 0 and 2 are triggered; each trigger is exactly 4 cycles; exactly 2 distance_valid strobes.
  - Ch 1 echo stuck high -> power[1] low for 30 cycles; distance 0xFF; timeout_flags[1] = 1. Next sweep with a 20-cycle echo -> flag clears, distance 10.
  - Ch 2 never rises -> distance 0xFF after the 50-cycle wait; no power cycle; flag set.
  - Echo width 1200 with OFFSET=5 -> saturates to 0xFF.
  - Mask 0 -> sweep_done with min 0xFF. continuous = 1 gives back-to-back sweeps. Reset asserted mid-POWER_CYCLE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ultrasound_array_scanner_if.sv
// Ultrasound array scanner bundle.
// Control inputs, sensor pins and result outputs.
interface ultrasound_array_scanner_if #(
  parameter int NUM_SENSORS = 6,
  parameter int DIST_WIDTH  = 8
);
  logic                   enable;
  logic                   continuous;
  logic [NUM_SENSORS-1:0] channel_mask;
  logic [NUM_SENSORS-1:0] ultrasound_response;
  logic [NUM_SENSORS-1:0] ultrasound_trigger;
  logic [NUM_SENSORS-1:0] ultrasound_power;
  logic [DIST_WIDTH-1:0]  distance;
  logic [3:0]             distance_channel;
  logic                   distance_valid;
  logic [NUM_SENSORS-1:0] timeout_flags;
  logic [DIST_WIDTH-1:0]  min_distance;
  logic [3:0]             min_channel;
  logic                   sweep_done;
  logic                   busy;

  // Controller side: rover logic and sensor pins.
  modport master (
    output enable,
    output continuous,
    output channel_mask,
    output ultrasound_response,
    input  ultrasound_trigger,
    input  ultrasound_power,
    input  distance,
    input  distance_channel,
    input  distance_valid,
    input  timeout_flags,
    input  min_distance,
    input  min_channel,
    input  sweep_done,
    input  busy
  );

  // Scanner side.
  modport slave (
    input  enable,
    input  continuous,
    input  channel_mask,
    input  ultrasound_response,
    output ultrasound_trigger,
    output ultrasound_power,
    output distance,
    output distance_channel,
    output distance_valid,
    output timeout_flags,
    output min_distance,
    output min_channel,
    output sweep_done,
    output busy
  );
endinterface

// File: rtl/ultrasound_array_scanner.sv
// Multi-channel HC-SR04 sweep controller.
// Pings masked channels in order, tracks nearest.
module ultrasound_array_scanner #(
  parameter int NUM_SENSORS         = 6,
  parameter int TRIGGER_CYCLES      = 275,
  parameter int RISE_TIMEOUT_CYCLES = 27000,
  parameter int ECHO_TIMEOUT_CYCLES = 1048576,
  parameter int POWER_CYCLE_CYCLES  = 27000000,
  parameter int SETTLE_CYCLES       = 1620000,
  parameter int DIST_SHIFT          = 12,
  parameter int DIST_OFFSET         = 5,
  parameter int DIST_WIDTH          = 8
) (
  input logic clock,
  input logic reset,
  ultrasound_array_scanner_if.slave bus
);

  localparam int TM1 = (TRIGGER_CYCLES > RISE_TIMEOUT_CYCLES)
                     ? TRIGGER_CYCLES : RISE_TIMEOUT_CYCLES;
  localparam int TM2 = (POWER_CYCLE_CYCLES > SETTLE_CYCLES)
                     ? POWER_CYCLE_CYCLES : SETTLE_CYCLES;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = $clog2(ECHO_TIMEOUT_CYCLES + 1);
  localparam int CHW  = (NUM_SENSORS > 1)
                      ? $clog2(NUM_SENSORS) : 1;
  localparam int DMAX = (1 << DIST_WIDTH) - 1;
  localparam logic [CHW-1:0] LAST = CHW'(NUM_SENSORS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SELECT,
    S_TRIGGER,
    S_WAIT_RISE,
    S_MEASURE,
    S_POWER,
    S_REPORT,
    S_SETTLE,
    S_END
  } state_t;

  state_t                 state;
  logic [NUM_SENSORS-1:0] sync1;
  logic [NUM_SENSORS-1:0] sync2;
  logic [NUM_SENSORS-1:0] mask_q;
  logic [NUM_SENSORS-1:0] trig_q;
  logic [NUM_SENSORS-1:0] power_q;
  logic [NUM_SENSORS-1:0] flags_q;
  logic [CHW-1:0]         ch;
  logic [TW-1:0]          timer;
  logic [CW-1:0]          count;
  logic [DIST_WIDTH-1:0]  result;
  logic [DIST_WIDTH-1:0]  best_d;
  logic [CHW-1:0]         best_c;
  logic [DIST_WIDTH-1:0]  dist_q;
  logic [CHW-1:0]         dch_q;
  logic                   dv_q;
  logic [DIST_WIDTH-1:0]  min_d;
  logic [CHW-1:0]         min_c;
  logic                   sd_q;
  logic [NUM_SENSORS-1:0] onehot;
  logic [31:0]            scaled;
  logic [DIST_WIDTH-1:0]  sat_d;
  logic                   echo;

  assign onehot = NUM_SENSORS'(1) << ch;
  assign echo   = sync2[ch];

  // Echo count to inches, clamped at the output range.
  always_comb begin
    scaled = 32'(count >> DIST_SHIFT) + 32'(DIST_OFFSET);
    sat_d  = scaled[DIST_WIDTH-1:0];
    if (scaled > 32'(DMAX)) sat_d = '1;
  end

  // Two-flop synchronizer on the raw echo pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.ultrasound_response;
      sync2 <= sync1;
    end
  end

  // Sweep sequencer with registered pin and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= S_IDLE;
      mask_q  <= '0;
      trig_q  <= '0;
      power_q <= '1;
      flags_q <= '0;
      ch      <= '0;
      timer   <= '0;
      count   <= '0;
      result  <= '1;
      best_d  <= '1;
      best_c  <= '0;
      dist_q  <= '0;
      dch_q   <= '0;
      dv_q    <= 1'b0;
      min_d   <= '1;
      min_c   <= '0;
      sd_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      sd_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.enable) begin
            mask_q <= bus.channel_mask;
            best_d <= '1;
            best_c <= '0;
            ch     <= '0;
            state  <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (mask_q[ch]) begin
            trig_q <= onehot;
            timer  <= '0;
            state  <= S_TRIGGER;
          end else if (ch == LAST) begin
            state <= S_END;
          end else begin
            ch <= ch + CHW'(1);
          end
        end
        S_TRIGGER: begin
          if (timer == TW'(TRIGGER_CYCLES - 1)) begin
            trig_q <= '0;
            timer  <= '0;
            state  <= S_WAIT_RISE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_WAIT_RISE: begin
          if (echo) begin
            count <= CW'(1);
            state <= S_MEASURE;
          end else if (timer == TW'(RISE_TIMEOUT_CYCLES - 1)) begin
            result      <= '1;
            flags_q[ch] <= 1'b1;
            state       <= S_REPORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_MEASURE: begin
          if (!echo) begin
            result      <= sat_d;
            flags_q[ch] <= 1'b0;
            state       <= S_REPORT;
          end else if (count == CW'(ECHO_TIMEOUT_CYCLES)) begin
            result      <= '1;
            flags_q[ch] <= 1'b1;
            power_q[ch] <= 1'b0;
            timer       <= '0;
            state       <= S_POWER;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_POWER: begin
          if (timer == TW'(POWER_CYCLE_CYCLES - 1)) begin
            power_q[ch] <= 1'b1;
            state       <= S_REPORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_REPORT: begin
          dist_q <= result;
          dch_q  <= ch;
          dv_q   <= 1'b1;
          if (result < best_d) begin
            best_d <= result;
            best_c <= ch;
          end
          timer <= '0;
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (timer == TW'(SETTLE_CYCLES - 1)) begin
            if (ch == LAST) begin
              state <= S_END;
            end else begin
              ch    <= ch + CHW'(1);
              state <= S_SELECT;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_END: begin
          min_d <= best_d;
          min_c <= best_c;
          sd_q  <= 1'b1;
          if (bus.continuous) begin
            mask_q <= bus.channel_mask;
            best_d <= '1;
            best_c <= '0;
            ch     <= '0;
            state  <= S_SELECT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ultrasound_trigger = trig_q;
  assign bus.ultrasound_power   = power_q;
  assign bus.distance           = dist_q;
  assign bus.distance_channel   = 4'(dch_q);
  assign bus.distance_valid     = dv_q;
  assign bus.timeout_flags      = flags_q;
  assign bus.min_distance       = min_d;
  assign bus.min_channel        = 4'(min_c);
  assign bus.sweep_done         = sd_q;
  assign bus.busy               = (state != S_IDLE);

endmodule

// File: tb/tb_ultrasound_array_scanner.sv
// Directed bench for ultrasound_array_scanner.
// Second instance has a long echo timeout for saturation.
module tb_ultrasound_array_scanner;
  localparam int N = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         en = 1'b0;
  logic         en_sat = 1'b0;
  logic         cont = 1'b0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] resp = '0;

  ultrasound_array_scanner_if #(.NUM_SENSORS(N), .DIST_WIDTH(8)) bus();
  ultrasound_array_scanner_if #(.NUM_SENSORS(N), .DIST_WIDTH(8)) sbus();

  assign bus.enable               = en;
  assign bus.continuous           = cont;
  assign bus.channel_mask         = mask;
  assign bus.ultrasound_response  = resp;
  assign sbus.enable              = en_sat;
  assign sbus.continuous          = cont;
  assign sbus.channel_mask        = mask;
  assign sbus.ultrasound_response = resp;

  ultrasound_array_scanner #(
    .NUM_SENSORS(N), .TRIGGER_CYCLES(4),
    .RISE_TIMEOUT_CYCLES(50), .ECHO_TIMEOUT_CYCLES(200),
    .POWER_CYCLE_CYCLES(30), .SETTLE_CYCLES(10),
    .DIST_SHIFT(2), .DIST_OFFSET(5), .DIST_WIDTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  ultrasound_array_scanner #(
    .NUM_SENSORS(N), .TRIGGER_CYCLES(4),
    .RISE_TIMEOUT_CYCLES(50), .ECHO_TIMEOUT_CYCLES(2000),
    .POWER_CYCLE_CYCLES(30), .SETTLE_CYCLES(10),
    .DIST_SHIFT(2), .DIST_OFFSET(5), .DIST_WIDTH(8)
  ) u_sat (
    .clock(clock),
    .reset(reset),
    .bus(sbus)
  );

  int checks = 0;
  int errors = 0;
  int sd_cnt, sat_sd, both_err, multi_trig;
  int tl[N], last_tl[N], tcnt[N], plow[N];
  int w[N];
  int dq[$];
  int cq[$];

  // Record strobes, trigger pulse lengths and power-off time.
  always @(negedge clock) begin
    if (bus.distance_valid === 1'b1) begin
      dq.push_back(int'(bus.distance));
      cq.push_back(int'(bus.distance_channel));
    end
    if (bus.sweep_done === 1'b1) sd_cnt++;
    if (sbus.sweep_done === 1'b1) sat_sd++;
    if (bus.distance_valid === 1'b1 && bus.sweep_done === 1'b1)
      both_err++;
    if ($countones(bus.ultrasound_trigger) > 1) multi_trig++;
    for (int i = 0; i < N; i++) begin
      if (bus.ultrasound_trigger[i] === 1'b1) begin
        tl[i]++;
      end else if (tl[i] != 0) begin
        last_tl[i] = tl[i];
        tcnt[i]++;
        tl[i] = 0;
      end
      if (bus.ultrasound_power[i] === 1'b0) plow[i]++;
    end
  end

  // Sensor model: echo w[i] cycles after the trigger falls.
  task automatic ping(input int i);
    repeat (3) @(negedge clock);
    if (w[i] < 0) begin
      resp[i] = 1'b1;
      for (int k = 0; k < 3000; k++) begin
        @(negedge clock);
        if (bus.ultrasound_power[i] === 1'b0) break;
      end
      resp[i] = 1'b0;
    end else if (w[i] > 0) begin
      resp[i] = 1'b1;
      repeat (w[i]) @(negedge clock);
      resp[i] = 1'b0;
    end
  endtask

  initial begin : responder
    logic [N-1:0] prev, now_t, fell;
    prev = '0;
    forever begin
      @(negedge clock);
      now_t = bus.ultrasound_trigger | sbus.ultrasound_trigger;
      fell  = prev & ~now_t;
      prev  = now_t;
      for (int i = 0; i < N; i++)
        if (fell[i] === 1'b1) ping(i);
    end
  end

  task automatic clear_stats();
    dq.delete();
    cq.delete();
    sd_cnt = 0;
    sat_sd = 0;
    for (int i = 0; i < N; i++) begin
      tl[i] = 0;
      last_tl[i] = 0;
      tcnt[i] = 0;
      plow[i] = 0;
    end
  endtask

  task automatic start_sweep(input bit s);
    @(negedge clock);
    if (s) en_sat = 1'b1;
    else en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    en_sat = 1'b0;
  endtask

  task automatic wait_sd(input bit s, input int target,
                         output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clock);
      if ((s ? sat_sd : sd_cnt) >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_stats();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.ultrasound_trigger !== 4'h0) begin
      errors++;
      $display("FAIL reset_trig got %h want 0", bus.ultrasound_trigger);
    end
    checks++;
    if (bus.ultrasound_power !== 4'hF) begin
      errors++;
      $display("FAIL reset_power got %h want f", bus.ultrasound_power);
    end
    checks++;
    if (bus.distance !== 8'h00 || bus.distance_channel !== 4'h0) begin
      errors++;
      $display("FAIL reset_dist got %h/%h want 00/0",
               bus.distance, bus.distance_channel);
    end
    checks++;
    if (bus.distance_valid !== 1'b0 || bus.sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b%b want 00",
               bus.distance_valid, bus.sweep_done);
    end
    checks++;
    if (bus.min_distance !== 8'hFF || bus.min_channel !== 4'h0) begin
      errors++;
      $display("FAIL reset_min got %h/%h want ff/0",
               bus.min_distance, bus.min_channel);
    end
    checks++;
    if (bus.timeout_flags !== 4'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags_busy got %h/%b want 0/0",
               bus.timeout_flags, bus.busy);
    end
  endtask

  task automatic test_full_sweep();
    bit ok;
    int ed[N];
    ed = '{15, 10, 20, 10};
    w = '{40, 20, 60, 20};
    mask = 4'hF;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_done got none want sweep_done");
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dq.size() <= i || dq[i] !== ed[i] || cq[i] !== i) begin
        errors++;
        $display("FAIL full_dist%0d got %0d/ch%0d want %0d/ch%0d",
                 i, dq.size() > i ? dq[i] : -1,
                 cq.size() > i ? cq[i] : -1, ed[i], i);
      end
      checks++;
      if (last_tl[i] !== 4) begin
        errors++;
        $display("FAIL full_trig%0d got %0d want 4", i, last_tl[i]);
      end
    end
    checks++;
    if (bus.min_distance !== 8'd10 || bus.min_channel !== 4'd1) begin
      errors++;
      $display("FAIL full_min got %0d/ch%0d want 10/ch1",
               bus.min_distance, bus.min_channel);
    end
    repeat (20) @(negedge clock);
    checks++;
    if (sd_cnt !== 1 || dq.size() !== 4) begin
      errors++;
      $display("FAIL full_counts got sd%0d dv%0d want sd1 dv4",
               sd_cnt, dq.size());
    end
  endtask

  task automatic test_mask();
    bit ok;
    w = '{20, 20, 20, 20};
    mask = 4'b0101;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    checks++;
    if (!ok || dq.size() !== 2) begin
      errors++;
      $display("FAIL mask_dv got %0d want 2", dq.size());
    end
    checks++;
    if (tcnt[0] !== 1 || tcnt[1] !== 0 ||
        tcnt[2] !== 1 || tcnt[3] !== 0) begin
      errors++;
      $display("FAIL mask_trig got %0d%0d%0d%0d want 1010",
               tcnt[0], tcnt[1], tcnt[2], tcnt[3]);
    end
    checks++;
    if (last_tl[0] !== 4 || last_tl[2] !== 4) begin
      errors++;
      $display("FAIL mask_len got %0d/%0d want 4/4",
               last_tl[0], last_tl[2]);
    end
    checks++;
    if (cq.size() != 2 || cq[0] !== 0 || cq[1] !== 2) begin
      errors++;
      $display("FAIL mask_ch got %0d entries want ch0,ch2",
               cq.size());
    end
  endtask

  task automatic test_stuck_echo();
    bit ok;
    w[1] = -1;
    mask = 4'b0010;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    checks++;
    if (!ok || bus.distance !== 8'hFF ||
        bus.distance_channel !== 4'd1) begin
      errors++;
      $display("FAIL stuck_dist got %h/ch%0d want ff/ch1",
               bus.distance, bus.distance_channel);
    end
    checks++;
    if (plow[1] !== 30 || plow[0] !== 0) begin
      errors++;
      $display("FAIL stuck_power got %0d want 30", plow[1]);
    end
    checks++;
    if (bus.timeout_flags !== 4'b0010) begin
      errors++;
      $display("FAIL stuck_flag got %b want 0010", bus.timeout_flags);
    end
    checks++;
    if (bus.min_distance !== 8'hFF || bus.min_channel !== 4'd0) begin
      errors++;
      $display("FAIL stuck_min got %h/%0d want ff/0",
               bus.min_distance, bus.min_channel);
    end
    w[1] = 20;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    checks++;
    if (!ok || bus.distance !== 8'd10 ||
        bus.timeout_flags !== 4'b0000) begin
      errors++;
      $display("FAIL recover got %0d/%b want 10/0000",
               bus.distance, bus.timeout_flags);
    end
    checks++;
    if (bus.min_distance !== 8'd10 || bus.min_channel !== 4'd1) begin
      errors++;
      $display("FAIL recover_min got %0d/%0d want 10/1",
               bus.min_distance, bus.min_channel);
    end
  endtask

  task automatic test_empty_mask();
    bit ok;
    mask = 4'b0000;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    checks++;
    if (!ok || bus.min_distance !== 8'hFF ||
        bus.min_channel !== 4'd0) begin
      errors++;
      $display("FAIL empty_min got %h/%0d want ff/0",
               bus.min_distance, bus.min_channel);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (dq.size() !== 0 || sd_cnt !== 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_counts got dv%0d sd%0d want dv0 sd1",
               dq.size(), sd_cnt);
    end
  endtask

  task automatic test_no_rise();
    bit ok;
    w[2] = 0;
    mask = 4'b0100;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    checks++;
    if (!ok || dq.size() != 1 || dq[0] !== 255 || cq[0] !== 2) begin
      errors++;
      $display("FAIL norise_dist got %0d entries want 255/ch2",
               dq.size());
    end
    checks++;
    if (bus.timeout_flags !== 4'b0100 || plow[2] !== 0) begin
      errors++;
      $display("FAIL norise_flag got %b/%0d want 0100/0",
               bus.timeout_flags, plow[2]);
    end
  endtask

  task automatic test_saturation();
    bit ok;
    w[0] = 1200;
    mask = 4'b0001;
    clear_stats();
    start_sweep(1'b1);
    wait_sd(1'b1, 1, ok);
    checks++;
    if (!ok || sbus.distance !== 8'hFF ||
        sbus.timeout_flags !== 4'h0) begin
      errors++;
      $display("FAIL sat_1200 got %h/%b want ff/0000",
               sbus.distance, sbus.timeout_flags);
    end
    w[0] = 900;
    clear_stats();
    start_sweep(1'b1);
    wait_sd(1'b1, 1, ok);
    checks++;
    if (!ok || sbus.distance !== 8'd230) begin
      errors++;
      $display("FAIL sat_900 got %0d want 230", sbus.distance);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    w[0] = 20;
    mask = 4'b0001;
    cont = 1'b1;
    clear_stats();
    start_sweep(1'b0);
    wait_sd(1'b0, 1, ok);
    cont = 1'b0;
    @(negedge clock);
    checks++;
    if (!ok || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy got %b want 1", bus.busy);
    end
    wait_sd(1'b0, 2, ok);
    @(negedge clock);
    checks++;
    if (!ok || bus.busy !== 1'b0 || dq.size() !== 2) begin
      errors++;
      $display("FAIL b2b_end got busy%b dv%0d want busy0 dv2",
               bus.busy, dq.size());
    end
    checks++;
    if (bus.min_distance !== 8'd10 || bus.min_channel !== 4'd0) begin
      errors++;
      $display("FAIL b2b_min got %0d/%0d want 10/0",
               bus.min_distance, bus.min_channel);
    end
  endtask

  task automatic test_reset_mid_power();
    bit ok;
    w[1] = -1;
    mask = 4'b0010;
    clear_stats();
    start_sweep(1'b0);
    ok = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (bus.ultrasound_power[1] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid_enter got power %b want 1101",
               bus.ultrasound_power);
    end
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.ultrasound_power !== 4'hF ||
        bus.ultrasound_trigger !== 4'h0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pins got %h/%h/%b want f/0/0",
               bus.ultrasound_power, bus.ultrasound_trigger, bus.busy);
    end
    checks++;
    if (bus.timeout_flags !== 4'h0 || bus.min_distance !== 8'hFF ||
        bus.distance !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_regs got %h/%h/%h want 0/ff/00",
               bus.timeout_flags, bus.min_distance, bus.distance);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_strobes();
    checks++;
    if (both_err !== 0 || multi_trig !== 0) begin
      errors++;
      $display("FAIL strobes got both%0d multi%0d want 0/0",
               both_err, multi_trig);
    end
  endtask

  initial begin
    both_err = 0;
    multi_trig = 0;
    w = '{20, 20, 20, 20};
    test_reset();
    test_full_sweep();
    test_mask();
    test_stuck_echo();
    test_empty_mask();
    test_no_rise();
    test_saturation();
    test_back_to_back();
    test_reset_mid_power();
    test_strobes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
